// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store engine: memory-op codes, FSM states and
// the misalignment rule.
package mem_access_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_MEM_OP = 4;
  localparam int unsigned MemTimeoutDefault = 255;

  typedef enum logic [DATA_WIDTH_MEM_OP-1:0] {
    MemOpNone = 4'd0,
    MemOpLb   = 4'd1,
    MemOpLh   = 4'd2,
    MemOpLw   = 4'd3,
    MemOpLbu  = 4'd4,
    MemOpLhu  = 4'd5,
    MemOpSb   = 4'd6,
    MemOpSh   = 4'd7,
    MemOpSw   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWaitR = 2'd2,
    StDone  = 2'd3
  } mem_state_e;

  function automatic logic is_misaligned(input logic [DATA_WIDTH_MEM_OP-1:0] op,
                                         input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      MemOpLh, MemOpLhu, MemOpSh: mis = off[0];
      MemOpLw, MemOpSw:           mis = |off;
      default:                    mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align_ext.sv
// Combinational load-lane extraction and sign/zero extension of bus read data.
module load_align_ext
  import mem_access_ctrl_pkg::*;
(
  input  logic [DATA_WIDTH_MEM_OP-1:0] op_i,
  input  logic [1:0]                   off_i,
  input  logic [31:0]                  rdata_i,
  output logic [31:0]                  data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];
    case (op_i)
      MemOpLb:  data_o = {{24{byte_sel[7]}}, byte_sel};
      MemOpLbu: data_o = {24'd0, byte_sel};
      MemOpLh:  data_o = {{16{half_sel[15]}}, half_sel};
      MemOpLhu: data_o = {16'd0, half_sel};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store engine driving a req/gnt/rvalid data bus.
// Optional bus watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = MemTimeoutDefault
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cpu_en_i,
  input  logic                         ex_en_i,
  input  logic [ADDR_W-1:0]            ex_alu_out_i,
  input  logic [DATA_WIDTH_MEM_OP-1:0] ex_mem_op_i,
  input  logic                         ex_memory_rd_en_i,
  input  logic                         ex_memory_we_en_i,
  input  logic [31:0]                  ex_store_data_i,
  input  logic [3:0]                   ex_store_byteena_i,
  output logic                         bus_req_o,
  output logic                         bus_we_o,
  output logic [ADDR_W-1:0]            bus_addr_o,
  output logic [31:0]                  bus_wdata_o,
  output logic [3:0]                   bus_be_o,
  input  logic                         bus_gnt_i,
  input  logic                         bus_rvalid_i,
  input  logic [31:0]                  bus_rdata_i,
  output logic                         mem_stall_req_o,
  output logic [31:0]                  mem_load_data_o,
  output logic                         mem_load_valid_o,
  output logic                         mem_misaligned_o,
  output logic                         mem_bus_fault_o
);

  mem_state_e                   state_q, state_d;
  logic                         req_q, req_d, we_q, we_d, is_load_q, is_load_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [31:0]                  wdata_q, wdata_d, ldata_q, ldata_d, ext_data;
  logic [3:0]                   be_q, be_d;
  logic [DATA_WIDTH_MEM_OP-1:0] op_q, op_d;
  logic [1:0]                   off_q, off_d;
  logic                         acc, misaligned, load_fault;

  assign acc        = ex_en_i & (ex_memory_rd_en_i | ex_memory_we_en_i);
  assign misaligned = is_misaligned(ex_mem_op_i, ex_alu_out_i[1:0]);

  load_align_ext u_load_align_ext (
    .op_i    (op_q),
    .off_i   (off_q),
    .rdata_i (bus_rdata_i),
    .data_o  (ext_data)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned TmrW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            fault_q, fault_d, timeout_hit;

  assign timeout_hit = (tmr_q == TmrW'(TIMEOUT_CYCLES - 1));
  assign load_fault  = fault_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign load_fault     = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    we_d             = we_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    be_d             = be_q;
    op_d             = op_q;
    off_d            = off_q;
    is_load_d        = is_load_q;
    ldata_d          = ldata_q;
    mem_stall_req_o  = 1'b0;
    mem_misaligned_o = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    fault_d          = fault_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (acc && misaligned) begin
          mem_misaligned_o = cpu_en_i;
        end else if (acc) begin
          mem_stall_req_o = 1'b1;
          state_d         = StReq;
          req_d           = 1'b1;
          we_d            = ex_memory_we_en_i;
          addr_d          = {ex_alu_out_i[ADDR_W-1:2], 2'b00};
          wdata_d         = ex_memory_we_en_i ? ex_store_data_i : 32'd0;
          be_d            = ex_memory_we_en_i ? ex_store_byteena_i : 4'hF;
          op_d            = ex_mem_op_i;
          off_d           = ex_alu_out_i[1:0];
          is_load_d       = ex_memory_rd_en_i;
        end
      end
      StReq: begin
        mem_stall_req_o = 1'b1;
        if (bus_gnt_i) begin
          req_d   = 1'b0;
          state_d = is_load_q ? StWaitR : StDone;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (timeout_hit) begin
          req_d   = 1'b0;
          state_d = StDone;
          fault_d = 1'b1;
        end
`endif
      end
      StWaitR: begin
        mem_stall_req_o = 1'b1;
        if (bus_rvalid_i) begin
          ldata_d = ext_data;
          state_d = StDone;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = StDone;
          fault_d = 1'b1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
`ifdef MEM_ACCESS_TIMEOUT_EN
        fault_d = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
`ifdef MEM_ACCESS_TIMEOUT_EN
    // Counter restarts on every entry to REQ/WAIT_R and runs while the state holds.
    tmr_d = (((state_q == StReq) || (state_q == StWaitR)) && (state_d == state_q)) ?
            tmr_q + 1'b1 : '0;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      op_q      <= '0;
      off_q     <= '0;
      is_load_q <= 1'b0;
      ldata_q   <= '0;
    end else if (cpu_en_i) begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      op_q      <= op_d;
      off_q     <= off_d;
      is_load_q <= is_load_d;
      ldata_q   <= ldata_d;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmr_q   <= '0;
      fault_q <= 1'b0;
    end else if (cpu_en_i) begin
      tmr_q   <= tmr_d;
      fault_q <= fault_d;
    end
  end

  assign mem_bus_fault_o = (state_q == StDone) & fault_q;
`else
  assign mem_bus_fault_o = 1'b0;
`endif

  assign bus_req_o        = req_q;
  assign bus_we_o         = we_q;
  assign bus_addr_o       = addr_q;
  assign bus_wdata_o      = wdata_q;
  assign bus_be_o         = be_q;
  assign mem_load_data_o  = ldata_q;
  assign mem_load_valid_o = (state_q == StDone) & is_load_q & ~load_fault;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (covers the watchdog when
// MEM_ACCESS_TIMEOUT_EN is defined).
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, cpu_en, ex_en, rd_en, we_en;
  logic [31:0] ex_addr, st_data, bus_rdata;
  logic [3:0]  ex_op, st_be;
  logic        bus_gnt, bus_rvalid;
  logic        bus_req, bus_we, stall, load_valid, misaligned, bus_fault;
  logic [31:0] bus_addr, bus_wdata, load_data;
  logic [3:0]  bus_be;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .cpu_en_i           (cpu_en),
    .ex_en_i            (ex_en),
    .ex_alu_out_i       (ex_addr),
    .ex_mem_op_i        (ex_op),
    .ex_memory_rd_en_i  (rd_en),
    .ex_memory_we_en_i  (we_en),
    .ex_store_data_i    (st_data),
    .ex_store_byteena_i (st_be),
    .bus_req_o          (bus_req),
    .bus_we_o           (bus_we),
    .bus_addr_o         (bus_addr),
    .bus_wdata_o        (bus_wdata),
    .bus_be_o           (bus_be),
    .bus_gnt_i          (bus_gnt),
    .bus_rvalid_i       (bus_rvalid),
    .bus_rdata_i        (bus_rdata),
    .mem_stall_req_o    (stall),
    .mem_load_data_o    (load_data),
    .mem_load_valid_o   (load_valid),
    .mem_misaligned_o   (misaligned),
    .mem_bus_fault_o    (bus_fault)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slot();
    ex_en = 1'b0; rd_en = 1'b0; we_en = 1'b0;
    ex_op = MemOpNone; ex_addr = '0; st_data = '0; st_be = '0;
  endtask

  task automatic set_slot(input logic [3:0] op, input logic [31:0] addr, input logic ld,
                          input logic [31:0] data, input logic [3:0] be);
    ex_en = 1'b1; ex_op = op; ex_addr = addr; rd_en = ld; we_en = ~ld;
    st_data = data; st_be = be;
  endtask

  // Load with grant on the first REQ cycle and rvalid on the next one.
  task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    set_slot(op, addr, 1'b1, 32'd0, 4'd0);
    #1;
    check1({tag, "_idle_stall"}, stall, 1'b1);
    check1({tag, "_idle_req"}, bus_req, 1'b0);
    step();
    check1({tag, "_req"}, bus_req, 1'b1);
    check32({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
    check32({tag, "_be"}, {28'd0, bus_be}, 32'hF);
    check1({tag, "_we"}, bus_we, 1'b0);
    check1({tag, "_req_stall"}, stall, 1'b1);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check1({tag, "_wait_req"}, bus_req, 1'b0);
    check1({tag, "_wait_stall"}, stall, 1'b1);
    check1({tag, "_wait_valid"}, load_valid, 1'b0);
    bus_rvalid = 1'b1; bus_rdata = rdata;
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    check1({tag, "_done_valid"}, load_valid, 1'b1);
    check32({tag, "_done_data"}, load_data, exp);
    check1({tag, "_done_stall"}, stall, 1'b0);
    check1({tag, "_done_fault"}, bus_fault, 1'b0);
    clear_slot();
    step();
    check1({tag, "_idle_valid"}, load_valid, 1'b0);
    check32({tag, "_hold_data"}, load_data, exp);
  endtask

  initial begin
    rst = 1'b1; cpu_en = 1'b1;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    clear_slot();
    repeat (2) @(posedge clk);
    #1;
    check1("rst_req", bus_req, 1'b0);
    check1("rst_we", bus_we, 1'b0);
    check32("rst_addr", bus_addr, 32'd0);
    check32("rst_wdata", bus_wdata, 32'd0);
    check32("rst_be", {28'd0, bus_be}, 32'd0);
    check32("rst_ldata", load_data, 32'd0);
    check1("rst_lvalid", load_valid, 1'b0);
    check1("rst_mis", misaligned, 1'b0);
    check1("rst_fault", bus_fault, 1'b0);
    check1("rst_stall", stall, 1'b0);
    rst = 1'b0;
    step();

    run_load("lw", MemOpLw, 32'h0000_1004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load("lb", MemOpLb, 32'h0000_7003, 32'h8012_3456, 32'hFFFF_FF80);
    run_load("lbu", MemOpLbu, 32'h0000_7003, 32'h8012_3456, 32'h0000_0080);
    run_load("lh", MemOpLh, 32'h0000_7002, 32'h8001_1234, 32'hFFFF_8001);
    run_load("lhu_lo", MemOpLhu, 32'h0000_7000, 32'h8001_F234, 32'h0000_F234);

    // SH with grant held off: request and payload must stay put for 5 cycles.
    set_slot(MemOpSh, 32'h0000_2002, 1'b0, 32'hABCD_0000, 4'b1100);
    #1;
    check1("sh_idle_stall", stall, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      check1("sh_req", bus_req, 1'b1);
      check1("sh_we", bus_we, 1'b1);
      check32("sh_addr", bus_addr, 32'h0000_2000);
      check32("sh_wdata", bus_wdata, 32'hABCD_0000);
      check32("sh_be", {28'd0, bus_be}, 32'hC);
      check1("sh_stall", stall, 1'b1);
      if (i == 4) bus_gnt = 1'b1;
      step();
    end
    bus_gnt = 1'b0;
    check1("sh_done_req", bus_req, 1'b0);
    check1("sh_done_stall", stall, 1'b0);
    check1("sh_done_valid", load_valid, 1'b0);
    clear_slot();
    step();

    // Misaligned word load: single pulse, no request, no stall.
    set_slot(MemOpLw, 32'h0000_1002, 1'b1, 32'd0, 4'd0);
    #1;
    check1("mis_pulse", misaligned, 1'b1);
    check1("mis_stall", stall, 1'b0);
    check1("mis_req", bus_req, 1'b0);
    step();
    clear_slot();
    #1;
    check1("mis_clear", misaligned, 1'b0);
    check1("mis_req_after", bus_req, 1'b0);
    set_slot(MemOpSh, 32'h0000_2001, 1'b0, 32'd0, 4'b0011);
    #1;
    check1("mis_sh", misaligned, 1'b1);
    step();
    clear_slot();

    // cpu_en low freezes REQ even while grant is offered.
    set_slot(MemOpSw, 32'h0000_5000, 1'b0, 32'h1234_5678, 4'hF);
    step();
    cpu_en = 1'b0; bus_gnt = 1'b1;
    step();
    step();
    check1("frz_req", bus_req, 1'b1);
    check1("frz_stall", stall, 1'b1);
    cpu_en = 1'b1;
    step();
    bus_gnt = 1'b0;
    check1("frz_done_req", bus_req, 1'b0);
    check1("frz_done_stall", stall, 1'b0);
    clear_slot();
    step();

    // Reset while in WAIT_R, then a late rvalid that must be ignored.
    set_slot(MemOpLw, 32'h0000_3000, 1'b1, 32'd0, 4'd0);
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check1("wr_stall", stall, 1'b1);
    rst = 1'b1;
    clear_slot();
    #1;
    check1("wr_rst_req", bus_req, 1'b0);
    check32("wr_rst_addr", bus_addr, 32'd0);
    check32("wr_rst_ldata", load_data, 32'd0);
    check1("wr_rst_stall", stall, 1'b0);
    step();
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    check1("late_valid", load_valid, 1'b0);
    check32("late_data", load_data, 32'd0);
    check1("late_stall", stall, 1'b0);
    run_load("post_rst", MemOpLw, 32'h0000_4008, 32'hCAFE_F00D, 32'hCAFE_F00D);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // No grant: watchdog ends the access after 4 REQ cycles.
    set_slot(MemOpLw, 32'h0000_6000, 1'b1, 32'd0, 4'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check1("to_req", bus_req, 1'b1);
      check1("to_stall", stall, 1'b1);
      step();
    end
    check1("to_req_drop", bus_req, 1'b0);
    check1("to_fault", bus_fault, 1'b1);
    check1("to_stall_rel", stall, 1'b0);
    check1("to_valid", load_valid, 1'b0);
    check32("to_data", load_data, 32'hCAFE_F00D);
    clear_slot();
    step();
    check1("to_fault_clr", bus_fault, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
